// File: rtl/bf16_to_fp8_drain.sv
// Drains an N x N array of BF16 results, re-quantises each to FP8 E4M3 (RNE, saturating),
// and streams them out four per 32-bit word over a valid/ready handshake.
module bf16_to_fp8_drain #(
   parameter int unsigned N = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [16*N*N-1:0] c_flat,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_data,
   output logic              out_last,
   output logic              done,
   output logic [15:0]       sat_count
);

   localparam int unsigned NE = N * N;
   localparam int unsigned IW = (NE > 1) ? $clog2(NE) : 1;

   typedef enum logic [1:0] {StIdle, StConv, StSend} state_e;

   // Returns {saturated, e4m3_byte}.
   function automatic logic [8:0] to_e4m3(input logic [15:0] x);
      logic        s;
      logic [7:0]  e8;
      logic [6:0]  m;
      logic [3:0]  ev;
      logic [7:0]  mag;
      logic        inc;
      logic [3:0]  sh;
      logic [17:0] ext;
      logic [7:0]  q;
      logic [8:0]  res;
      s   = x[15];
      e8  = x[14:7];
      m   = x[6:0];
      ev  = '0;
      mag = '0;
      inc = 1'b0;
      sh  = '0;
      ext = '0;
      q   = '0;
      res = {1'b0, s, 7'h00};
      if (e8 == 8'd0) begin
         res = {1'b0, s, 7'h00};
      end else if (e8 > 8'd135) begin
         // Covers e > 8 as well as BF16 inf/NaN.
         res = {1'b1, s, 7'h7E};
      end else if (e8 >= 8'd121) begin
         ev  = 4'(e8 - 8'd120);
         mag = {1'b0, ev, m[6:4]};
         inc = m[3] & ((|m[2:0]) | m[4]);
         mag = mag + {7'd0, inc};
         if (mag > 8'h7E) begin
            res = {1'b1, s, 7'h7E};
         end else begin
            res = {1'b0, s, 7'(mag)};
         end
      end else if (e8 >= 8'd115) begin
         // Subnormal target: shift by 125 - e8 (5..10), round on the shifted-out bits.
         sh  = 4'(8'd125 - e8);
         ext = {1'b1, m, 10'd0} >> sh;
         q   = ext[17:10];
         inc = ext[9] & ((|ext[8:0]) | q[0]);
         q   = q + {7'd0, inc};
         res = {1'b0, s, 7'(q)};
      end
      return res;
   endfunction

   state_e            state_q, state_d;
   logic [16*NE-1:0]  snap_q, snap_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [31:0]       pack_q, pack_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              done_q, done_d;
   logic [15:0]       sat_q, sat_d;

   logic [8:0]        cv;
   logic              is_last;
   logic [1:0]        bsel;

   always_comb begin
      state_d     = state_q;
      snap_d      = snap_q;
      idx_d       = idx_q;
      pack_d      = pack_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      done_d      = 1'b0;
      sat_d       = sat_q;
      cv          = to_e4m3(snap_q[16*idx_q +: 16]);
      is_last     = (idx_q == IW'(NE - 1));
      bsel        = 2'(idx_q);

      unique case (state_q)
         StIdle: begin
            if (start) begin
               snap_d  = c_flat;
               sat_d   = '0;
               pack_d  = '0;
               idx_d   = '0;
               state_d = StConv;
            end
         end
         StConv: begin
            pack_d[8*bsel +: 8] = cv[7:0];
            idx_d = idx_q + 1'b1;
            if (cv[8] && (sat_q != 16'hFFFF)) begin
               sat_d = sat_q + 16'd1;
            end
            if ((bsel == 2'd3) || is_last) begin
               out_valid_d = 1'b1;
               out_last_d  = is_last;
               state_d     = StSend;
            end
         end
         StSend: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               pack_d      = '0;
               if (out_last_q) begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end else begin
                  state_d = StConv;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         snap_q      <= '0;
         idx_q       <= '0;
         pack_q      <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         sat_q       <= '0;
      end else begin
         state_q     <= state_d;
         snap_q      <= snap_d;
         idx_q       <= idx_d;
         pack_q      <= pack_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         sat_q       <= sat_d;
      end
   end

   assign busy      = (state_q != StIdle);
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = pack_q;
   assign done      = done_q;
   assign sat_count = sat_q;

endmodule

// File: tb/tb_bf16_to_fp8_drain.sv
// Scoreboard bench: a real-valued nearest-code model predicts every word; monitors check handshakes.
module tb_bf16_to_fp8_drain;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic          rst2, start2, ready2, busy2, valid2, last2, done2;
   logic [63:0]   c2;
   logic [31:0]   data2;
   logic [15:0]   sat2;
   logic          rst3, start3, ready3, busy3, valid3, last3, done3;
   logic [143:0]  c3;
   logic [31:0]   data3;
   logic [15:0]   sat3;

   logic [32:0] q2[$], q3[$];
   logic [15:0] sq2[$], sq3[$];
   logic [32:0] e2, e3;
   int          hs3 = 0;
   bit          last_seen2 = 0, last_seen3 = 0;

   bf16_to_fp8_drain #(.N(2)) u_dut2 (
      .clk(clk), .rst(rst2), .start(start2), .c_flat(c2), .busy(busy2), .out_valid(valid2),
      .out_ready(ready2), .out_data(data2), .out_last(last2), .done(done2), .sat_count(sat2)
   );

   bf16_to_fp8_drain #(.N(3)) u_dut3 (
      .clk(clk), .rst(rst3), .start(start3), .c_flat(c3), .busy(busy3), .out_valid(valid3),
      .out_ready(ready3), .out_data(data3), .out_last(last3), .done(done3), .sat_count(sat3)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s at %0t", nm, $time);
   endtask

   function automatic real pow2(input int e);
      real r = 1.0;
      if (e >= 0) repeat (e) r = r * 2.0;
      else repeat (-e) r = r / 2.0;
      return r;
   endfunction

   // Value of an E4M3 magnitude code; 0x7F/0x80 are treated as the hypothetical next codes.
   function automatic real code_val(input int c);
      int ex = c / 8;
      int mm = c % 8;
      if (ex == 0) return mm * pow2(-9);
      return (8 + mm) * pow2(ex - 10);
   endfunction

   // Nearest representable magnitude, ties to even code; beyond 0x7E means saturation.
   function automatic logic [8:0] ref_cvt(input logic [15:0] x);
      int  e8 = int'(x[14:7]);
      int  m  = int'(x[6:0]);
      real v, d, bd;
      int  best;
      if (e8 == 255) return {1'b1, x[15], 7'h7E};
      if (e8 == 0) return {1'b0, x[15], 7'h00};
      v = (128 + m) * pow2(e8 - 134);
      best = 0;
      bd = v;
      for (int c = 1; c <= 128; c++) begin
         d = v - code_val(c);
         if (d < 0.0) d = -d;
         if (d < bd || (d == bd && (c % 2) == 0)) begin
            bd = d;
            best = c;
         end
      end
      if (best > 126) return {1'b1, x[15], 7'h7E};
      return {1'b0, x[15], 7'(best)};
   endfunction

   task automatic expect_drain(input int which, input logic [15:0] els[9], input int n);
      logic [31:0] w = '0;
      logic [8:0]  r;
      int          sat = 0;
      for (int i = 0; i < n; i++) begin
         r = ref_cvt(els[i]);
         if (r[8]) sat++;
         w[8*(i%4) +: 8] = r[7:0];
         if ((i % 4) == 3 || i == n - 1) begin
            if (which == 2) q2.push_back({(i == n - 1), w});
            else q3.push_back({(i == n - 1), w});
            w = '0;
         end
      end
      if (which == 2) sq2.push_back(16'(sat));
      else sq3.push_back(16'(sat));
   endtask

   function automatic logic [15:0] rnd_bf16();
      logic [7:0] e8;
      case ($urandom % 8)
         0: e8 = 8'd0;
         1: e8 = 8'd255;
         2: e8 = 8'($urandom_range(100, 121));
         3, 4: e8 = 8'($urandom_range(118, 140));
         default: e8 = 8'($urandom_range(121, 135));
      endcase
      return {1'($urandom % 2), e8, 7'($urandom % 128)};
   endfunction

   always @(negedge clk) begin
      if (!rst2 && valid2 && ready2) begin
         if (q2.size() == 0) fail_now("dut2 unexpected word");
         else begin
            e2 = q2.pop_front();
            chk("dut2 word", 64'(data2), 64'(e2[31:0]));
            chk("dut2 last", 64'(last2), 64'(e2[32]));
            last_seen2 = e2[32];
         end
      end
      if (!rst2 && done2) begin
         chk("dut2 done after last word", 64'(last_seen2), 64'(1));
         last_seen2 = 0;
         if (sq2.size() == 0) fail_now("dut2 unexpected done");
         else chk("dut2 sat_count", 64'(sat2), 64'(sq2.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (!rst3 && valid3 && ready3) begin
         if (q3.size() == 0) fail_now("dut3 unexpected word");
         else begin
            e3 = q3.pop_front();
            chk("dut3 word", 64'(data3), 64'(e3[31:0]));
            chk("dut3 last", 64'(last3), 64'(e3[32]));
            last_seen3 = e3[32];
         end
         hs3++;
      end
      if (!rst3 && done3) begin
         chk("dut3 done after last word", 64'(last_seen3), 64'(1));
         last_seen3 = 0;
         if (sq3.size() == 0) fail_now("dut3 unexpected done");
         else chk("dut3 sat_count", 64'(sat3), 64'(sq3.pop_front()));
      end
   end

   task automatic load_start(input int which, input logic [15:0] els[9]);
      @(posedge clk) #1;
      if (which == 2) begin
         for (int i = 0; i < 4; i++) c2[16*i +: 16] = els[i];
         start2 = 1'b1;
      end else begin
         for (int i = 0; i < 9; i++) c3[16*i +: 16] = els[i];
         start3 = 1'b1;
      end
      @(posedge clk) #1;
      start2 = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic run_drain(input int which, input logic [15:0] els[9], input bit rnd);
      bit ok = 0;
      bit r;
      expect_drain(which, els, (which == 2) ? 4 : 9);
      load_start(which, els);
      for (int t = 0; t < 300; t++) begin
         if ((which == 2 && done2) || (which == 3 && done3)) begin
            ok = 1;
            break;
         end
         r = rnd ? (($urandom % 3) != 0) : 1'b1;
         if (which == 2) ready2 = r;
         else ready3 = r;
         @(posedge clk) #1;
      end
      if (!ok) fail_now("drain timeout");
   endtask

   // Directed N=2 drain: checks the word while held, optionally stalls and pokes start.
   task automatic direct2(input string nm, input logic [15:0] els[9], input logic [31:0] wexp,
                          input logic [15:0] sexp, input int stall);
      bit ok = 0;
      expect_drain(2, els, 4);
      ready2 = 1'b0;
      load_start(2, els);
      for (int t = 0; t < 20; t++) begin
         if (valid2) begin
            ok = 1;
            break;
         end
         @(posedge clk) #1;
      end
      if (!ok) fail_now({nm, " valid timeout"});
      chk({nm, " word"}, 64'(data2), 64'(wexp));
      for (int s = 0; s < stall; s++) begin
         @(posedge clk) #1;
         chk({nm, " held word"}, 64'(data2), 64'(wexp));
         chk({nm, " held busy/valid"}, 64'({busy2, valid2}), 64'(2'b11));
         if (s == 1) begin
            c2 = ~c2;
            start2 = 1'b1;
         end else begin
            start2 = 1'b0;
         end
      end
      start2 = 1'b0;
      ready2 = 1'b1;
      @(posedge clk) #1;
      chk({nm, " done pulse"}, 64'(done2), 64'(1));
      chk({nm, " sat_count"}, 64'(sat2), 64'(sexp));
      @(posedge clk) #1;
      chk({nm, " idle after done"}, 64'({busy2, done2, valid2}), 64'(0));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] els[9];
      int          lat;
      int          h;
      bit          ok;

      rst2 = 1'b1; rst3 = 1'b1;
      start2 = 1'b0; start3 = 1'b0;
      ready2 = 1'b1; ready3 = 1'b1;
      c2 = '0; c3 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("dut2 reset outputs", 64'({busy2, valid2, last2, done2, data2, sat2}), 64'(0));
      chk("dut3 reset outputs", 64'({busy3, valid3, last3, done3, data3, sat3}), 64'(0));
      rst2 = 1'b0; rst3 = 1'b0;

      // Basic drain with latency measurement.
      els = '{16'h3F80, 16'h43E0, 16'h3B00, 16'hC000, 0, 0, 0, 0, 0};
      expect_drain(2, els, 4);
      @(posedge clk) #1;
      for (int i = 0; i < 4; i++) c2[16*i +: 16] = els[i];
      start2 = 1'b1;
      @(posedge clk) #1;
      start2 = 1'b0;
      chk("basic busy after start", 64'(busy2), 64'(1));
      lat = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (valid2) begin
            lat = n;
            break;
         end
      end
      chk("basic latency to out_valid", 64'(lat), 64'(4));
      chk("basic word", 64'(data2), 64'(32'hC0017E38));
      chk("basic last", 64'(last2), 64'(1));
      @(negedge clk);
      chk("basic done at k+5", 64'(done2), 64'(1));
      @(negedge clk);
      chk("basic busy dropped", 64'(busy2), 64'(0));

      els = '{16'h3F88, 16'h3F98, 16'h43E8, 16'h0000, 0, 0, 0, 0, 0};
      direct2("rne", els, 32'h007E3A38, 16'd0, 0);
      els = '{16'h43EC, 16'h43FA, 16'h7F80, 16'hFF80, 0, 0, 0, 0, 0};
      direct2("saturation", els, 32'hFE7E7E7E, 16'd4, 0);
      els = '{16'h3B00, 16'h3C00, 16'h3A00, 16'h3A80, 0, 0, 0, 0, 0};
      direct2("subnormal", els, 32'h00000401, 16'd0, 0);
      els = '{16'h3C7F, 16'hBBFF, 16'h8000, 16'h3F80, 0, 0, 0, 0, 0};
      direct2("subnormal carry", els, 32'h38808408, 16'd0, 0);
      els = '{16'h3F80, 16'h43E0, 16'h3B00, 16'hC000, 0, 0, 0, 0, 0};
      direct2("backpressure", els, 32'hC0017E38, 16'd0, 6);

      // N=3: full drain, then reset after word 0, then a full drain again.
      for (int i = 0; i < 9; i++) els[i] = rnd_bf16();
      run_drain(3, els, 0);
      for (int i = 0; i < 9; i++) els[i] = rnd_bf16();
      h = hs3;
      expect_drain(3, els, 9);
      ready3 = 1'b1;
      load_start(3, els);
      ok = 0;
      for (int t = 0; t < 40; t++) begin
         @(posedge clk) #1;
         if (hs3 > h) begin
            ok = 1;
            break;
         end
      end
      if (!ok) fail_now("dut3 word 0 timeout");
      rst3 = 1'b1;
      q3.delete();
      sq3.delete();
      last_seen3 = 0;
      @(posedge clk) #1;
      chk("dut3 mid-drain reset outputs", 64'({busy3, valid3, last3, done3, data3, sat3}),
          64'(0));
      rst3 = 1'b0;
      run_drain(3, els, 1);

      for (int k = 0; k < 25; k++) begin
         for (int i = 0; i < 9; i++) els[i] = rnd_bf16();
         run_drain(2, els, 1);
         for (int i = 0; i < 9; i++) els[i] = rnd_bf16();
         run_drain(3, els, 1);
      end

      repeat (4) @(posedge clk);
      #1;
      chk("dut2 scoreboard empty", 64'(q2.size() + sq2.size()), 64'(0));
      chk("dut3 scoreboard empty", 64'(q3.size() + sq3.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
